reg_file_param: RTL and testbench

//  Parametrised register file: 1 write port, 2 independent read ports (A, B).

---
 rtl/reg_file_param_if.sv | 30 +++
 rtl/reg_file_param.sv | 106 ++++++++++
 tb/tb_reg_file_param.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// reg_file_param_if: write port plus two read ports of the register file.
// master drives we/waddr/wdata/re_x/raddr_x; slave returns rdata_x/rvalid_x.
interface reg_file_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_b;

  modport master (
    output we, waddr, wdata,
    output re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  we, waddr, wdata,
    input  re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: 1W/2R register file, optional hard-zero r0, bypass, sync read.
// Ports: clk, clr_n (async active-low clear), bus (slave side of the RF bus).
module reg_file_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1,
  parameter bit SYNC_READ = 1'b1
) (
  input logic             clk,
  input logic             clr_n,
  reg_file_param_if.slave bus
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              wr_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [1:0]        re;
  logic [WIDTH-1:0]  rval  [2];

  assign raddr[0] = bus.raddr_a;
  assign raddr[1] = bus.raddr_b;
  assign re       = {bus.re_b, bus.re_a};

  always_comb begin
    wr_ok = bus.we
         && (int'(bus.waddr) < DEPTH)
         && !(ZERO_REG && bus.waddr == '0);
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[bus.waddr] = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read value per port: out-of-range and hard-zero
  // addresses win over the bypass path.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rval[p] = '0;
      if ((int'(raddr[p]) < DEPTH)
          && !(ZERO_REG && raddr[p] == '0)) begin
        if (BYPASS && bus.we && bus.waddr == raddr[p]) begin
          rval[p] = bus.wdata;
        end else begin
          rval[p] = mem_q[raddr[p]];
        end
      end
    end
  end

  if (SYNC_READ) begin : g_sync
    logic [WIDTH-1:0] rdata_q [2];
    logic [WIDTH-1:0] rdata_d [2];
    logic [1:0]       rvalid_q;
    logic [1:0]       rvalid_d;

    // Data holds its last value when no read is issued.
    always_comb begin
      rvalid_d = re;
      for (int p = 0; p < 2; p++) begin
        rdata_d[p] = re[p] ? rval[p] : rdata_q[p];
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        rdata_q[0] <= '0;
        rdata_q[1] <= '0;
        rvalid_q   <= '0;
      end else begin
        rdata_q    <= rdata_d;
        rvalid_q   <= rvalid_d;
      end
    end

    assign bus.rdata_a  = rdata_q[0];
    assign bus.rdata_b  = rdata_q[1];
    assign bus.rvalid_a = rvalid_q[0];
    assign bus.rvalid_b = rvalid_q[1];
  end else begin : g_comb
    // Outputs forced quiet while clear is held.
    logic [1:0] rv;

    assign rv           = re & {2{clr_n}};
    assign bus.rdata_a  = rv[0] ? rval[0] : '0;
    assign bus.rdata_b  = rv[1] ? rval[1] : '0;
    assign bus.rvalid_a = rv[0];
    assign bus.rvalid_b = rv[1];
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: three configurations driven with identical stimulus,
// each compared against an array-based model of the register-file rules.
module tb_reg_file_param;

  logic        clk;
  logic        clr_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re_a;
  logic        re_b;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;

  logic [31:0] rd [3][2];
  logic        rv [3][2];

  int errs;
  int checks;

  // Config 0: defaults. Config 1: DEPTH=20, no zero reg, no bypass.
  // Config 2: defaults with combinational reads.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    assign bus.we      = we;
    assign bus.waddr   = waddr;
    assign bus.wdata   = wdata;
    assign bus.re_a    = re_a;
    assign bus.re_b    = re_b;
    assign bus.raddr_a = raddr_a;
    assign bus.raddr_b = raddr_b;
    assign rd[g][0]    = bus.rdata_a;
    assign rd[g][1]    = bus.rdata_b;
    assign rv[g][0]    = bus.rvalid_a;
    assign rv[g][1]    = bus.rvalid_b;

    reg_file_param #(
      .WIDTH    (32),
      .DEPTH    ((g == 1) ? 20 : 32),
      .ADDR_W   (5),
      .ZERO_REG (g != 1),
      .BYPASS   (g != 1),
      .SYNC_READ(g != 2)
    ) u_dut (
      .clk  (clk),
      .clr_n(clr_n),
      .bus  (bus.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [31:0] mem [3][32];
  logic [31:0] er  [3][2];
  logic        ev  [3][2];

  function automatic int cdep(int c);
    return (c == 1) ? 20 : 32;
  endfunction
  function automatic bit czr(int c);
    return c != 1;
  endfunction
  function automatic bit cbyp(int c);
    return c != 1;
  endfunction
  function automatic bit csync(int c);
    return c != 2;
  endfunction

  function automatic logic [31:0] rule(int c, logic [4:0] r);
    if (int'(r) >= cdep(c)) return '0;
    if (czr(c) && r == 5'd0) return '0;
    if (cbyp(c) && we && waddr == r) return wdata;
    return mem[c][r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 32; a++) mem[c][a] = '0;
      for (int p = 0; p < 2; p++) begin
        er[c][p] = '0;
        ev[c][p] = 1'b0;
      end
    end
  endtask

  // One clock: comb outputs checked before the edge, model updated at
  // the edge, registered outputs checked just after it.
  task automatic step();
    logic [4:0] ra [2];
    logic       rq [2];
    ra = '{raddr_a, raddr_b};
    rq = '{re_a, re_b};
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!csync(c)) begin
          chk($sformatf("c%0d_p%0d_cdata", c, p), rd[c][p],
              rq[p] ? rule(c, ra[p]) : 32'h0);
          chk($sformatf("c%0d_p%0d_cvalid", c, p),
              {31'h0, rv[c][p]}, {31'h0, rq[p]});
        end else if (rq[p]) begin
          er[c][p] = rule(c, ra[p]);
          ev[c][p] = 1'b1;
        end else begin
          ev[c][p] = 1'b0;
        end
      end
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (we && int'(waddr) < cdep(c) && !(czr(c) && waddr == 5'd0))
        mem[c][waddr] = wdata;
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      if (csync(c)) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("c%0d_p%0d_data", c, p), rd[c][p], er[c][p]);
          chk($sformatf("c%0d_p%0d_valid", c, p),
              {31'h0, rv[c][p]}, {31'h0, ev[c][p]});
        end
      end
    end
  endtask

  task automatic idle();
    we   = 1'b0;
    re_a = 1'b0;
    re_b = 1'b0;
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    clr_n   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    re_a    = 1'b0;
    re_b    = 1'b0;
    raddr_a = '0;
    raddr_b = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 2; p++) begin
        chk("por_data", rd[c][p], 32'h0);
        chk("por_valid", {31'h0, rv[c][p]}, 32'h0);
      end
    end
    clr_n = 1'b1;

    // Reset mid-cycle with a read pending.
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_0003;
    step();
    we = 1'b0; re_a = 1'b1; raddr_a = 5'd3;
    re_b = 1'b1; raddr_b = 5'd3;
    step();
    chk("pre_rst_valid", {31'h0, rv[0][0]}, 32'h1);
    #2 clr_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 2; p++) begin
        chk("arst_data", rd[c][p], 32'h0);
        chk("arst_valid", {31'h0, rv[c][p]}, 32'h0);
      end
    end
    #1 clr_n = 1'b1;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      re_a = 1'b1; raddr_a = 5'(a);
      re_b = 1'b1; raddr_b = 5'(31 - a);
      step();
    end

    // Write then read back.
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    step();
    idle();
    re_a = 1'b1; raddr_a = 5'd5;
    step();
    chk("r5_data", rd[0][0], 32'hDEAD_BEEF);
    chk("r5_valid", {31'h0, rv[0][0]}, 32'h1);
    idle();
    step();
    chk("r5_idle_valid", {31'h0, rv[0][0]}, 32'h0);
    chk("r5_idle_hold", rd[0][0], 32'hDEAD_BEEF);

    // Hard-zero entry 0.
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
    step();
    idle();
    re_a = 1'b1; raddr_a = 5'd0;
    re_b = 1'b1; raddr_b = 5'd0;
    step();
    chk("r0_a", rd[0][0], 32'h0);
    chk("r0_b", rd[0][1], 32'h0);
    chk("r0_nozero", rd[1][0], 32'h1234_5678);

    // Write/read collision.
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'h2;
    re_a = 1'b1; raddr_a = 5'd7;
    step();
    chk("coll_bypass", rd[0][0], 32'h2);
    chk("coll_nobypass", rd[1][0], 32'h1);
    idle();
    re_a = 1'b1; raddr_a = 5'd7;
    step();
    chk("coll_after", rd[0][0], 32'h2);
    chk("coll_after_nb", rd[1][0], 32'h2);

    // Out-of-range address on the DEPTH=20 instance.
    idle();
    we = 1'b1; waddr = 5'd25; wdata = 32'hCAFE_0025;
    step();
    idle();
    re_a = 1'b1; raddr_a = 5'd25;
    step();
    chk("oor_read", rd[1][0], 32'h0);
    for (int a = 0; a < 32; a++) begin
      re_a = 1'b1; raddr_a = 5'(a);
      re_b = 1'b1; raddr_b = 5'(a);
      step();
    end

    // Address sweep for combinational reads.
    idle();
    for (int a = 1; a < 32; a++) begin
      re_a = 1'b1; raddr_a = 5'(a);
      step();
    end

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      re_a    = 1'($urandom_range(0, 1));
      re_b    = 1'($urandom_range(0, 1));
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr
                                            : 5'($urandom_range(0, 31));
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a
                                            : 5'($urandom_range(0, 31));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
